msg_seq7: RTL

//  Parametrised seven-segment message sequencer. Steps through a MSG_LEN-character

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_glyph.sv | 31 +++
 rtl/msg_seq7.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared character codes, FSM state encoding and glyph patterns for the
// seven-segment message sequencer.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [3:0] CH_H     = 4'hA;
    localparam logic [3:0] CH_E     = 4'hB;
    localparam logic [3:0] CH_L     = 4'hC;
    localparam logic [3:0] CH_O     = 4'hD;
    localparam logic [3:0] CH_P     = 4'hE;
    localparam logic [3:0] CH_BLANK = 4'hF;

    // Active-low patterns, bit 7 is the decimal point (kept off)
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit character code to active-low seven-segment pattern.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (code)
            4'h0:     seg = SEG_0;
            4'h1:     seg = SEG_1;
            4'h2:     seg = SEG_2;
            4'h3:     seg = SEG_3;
            4'h4:     seg = SEG_4;
            4'h5:     seg = SEG_5;
            4'h6:     seg = SEG_6;
            4'h7:     seg = SEG_7;
            4'h8:     seg = SEG_8;
            4'h9:     seg = SEG_9;
            CH_H:     seg = SEG_H;
            CH_E:     seg = SEG_E;
            CH_L:     seg = SEG_L;
            CH_O:     seg = SEG_O;
            CH_P:     seg = SEG_P;
            CH_BLANK: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/msg_seq7.sv
// Seven-segment message sequencer with per-glyph dwell and optional blank gap.
// Define MSG_SEQ7_BLINK_EN to blink the last glyph while in DONE.
module msg_seq7
    import seg7_pkg::*;
#(
    parameter int unsigned          MSG_LEN = 5,
    parameter logic [4*MSG_LEN-1:0] MSG     = 20'hDCCBA,
    parameter int unsigned          DWELL   = 4,
    parameter int unsigned          GAP     = 1
) (
    input  logic                       ck,
    input  logic                       rs,
    input  logic                       start,
    input  logic                       loop,
    input  logic                       pause,
    output logic [7:0]                 seg,
    output logic [$clog2(MSG_LEN)-1:0] idx,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned IW = $clog2(MSG_LEN);
    localparam int unsigned CW = $clog2(DWELL + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [IW-1:0] idx_n;
    logic          show_n;
    logic [3:0]    code_n;
    logic [7:0]    glyph;
`ifdef MSG_SEQ7_BLINK_EN
    logic          blink, blink_n;
`endif

    // Glyph is looked up from the index about to be registered, so seg and idx change together
    assign code_n = MSG[{idx_n, 2'b00} +: 4];

    seg7_glyph u_glyph (
        .code (code_n),
        .seg  (glyph)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        idx_n   = idx;
        show_n  = 1'b0;
`ifdef MSG_SEQ7_BLINK_EN
        blink_n = blink;
`endif
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_SHOW;
                    idx_n   = '0;
                    cnt_n   = '0;
                    show_n  = 1'b1;
                end else if (state == ST_DONE) begin
`ifdef MSG_SEQ7_BLINK_EN
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        blink_n = ~blink;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                    show_n = ~blink_n;
`endif
                end
            end
            ST_SHOW: begin
                show_n = 1'b1;
                if (cnt != CNT_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else if (idx == IDX_LAST && !loop) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
`ifdef MSG_SEQ7_BLINK_EN
                    blink_n = 1'b0;
`else
                    show_n  = 1'b0;
`endif
                end else if (GAP > 0) begin
                    state_n = ST_GAP;
                    gcnt_n  = '0;
                    show_n  = 1'b0;
                end else begin
                    idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    cnt_n = '0;
                end
            end
            ST_GAP: begin
                if (gcnt != GAP_LAST) begin
                    gcnt_n = gcnt + 1'b1;
                end else begin
                    state_n = ST_SHOW;
                    idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    cnt_n   = '0;
                    show_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rs) begin
            state <= ST_IDLE;
            cnt   <= '0;
            gcnt  <= '0;
            idx   <= '0;
            seg   <= '1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MSG_SEQ7_BLINK_EN
            blink <= 1'b0;
`endif
        end else if (!pause) begin
            state <= state_n;
            cnt   <= cnt_n;
            gcnt  <= gcnt_n;
            idx   <= idx_n;
            seg   <= show_n ? glyph : '1;
            busy  <= (state_n == ST_SHOW) || (state_n == ST_GAP);
            done  <= (state_n == ST_DONE);
`ifdef MSG_SEQ7_BLINK_EN
            blink <= blink_n;
`endif
        end
    end

endmodule
